// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// sequencer state encoding and ABI register indices.
package rf_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;

    // ABI name a0: first argument / return value register.
    localparam int RF_ABI_A0 = 10;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_write_arbiter.sv
// Resolves NWR write ports into one strobe and one data word per register
// entry; the highest-numbered matching port wins, index 0 is filtered if hardwired.
import rf_pkg::*;

module rf_write_arbiter #(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic [NWR-1:0]        i_en,
    input  logic [NWR*AW-1:0]     i_idx,
    input  logic [NWR*XLEN-1:0]   i_data,
    output logic [NREGS-1:0]      o_we,
    output logic [NREGS*XLEN-1:0] o_wdata
);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_entry
            logic            w_we;
            logic [XLEN-1:0] w_data;

            always_comb begin
                w_we   = 1'b0;
                w_data = '0;
                // Ascending scan: a later (higher) port overrides earlier matches.
                for (int p = 0; p < NWR; p++) begin
                    if (i_en[p] && (i_idx[p*AW +: AW] == AW'(gi))) begin
                        w_we   = 1'b1;
                        w_data = i_data[p*XLEN +: XLEN];
                    end
                end
                if ((ZERO_REG != 0) && (gi == 0)) begin
                    w_we = 1'b0;
                end
            end

            assign o_we[gi]                  = w_we;
            assign o_wdata[gi*XLEN +: XLEN]  = w_data;
        end
    endgenerate

endmodule

// File: rtl/multiport_regfile.sv
// Multi-port integer register file with busy scoreboard, sequenced clear
// and debug tap. Optional same-cycle write forwarding: define RF_BYPASS_EN.
import rf_pkg::*;

module multiport_regfile #(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NRD*AW-1:0]     i_rd_idx,
    output logic [NRD*XLEN-1:0]   o_rd_data,
    output logic [NRD-1:0]        o_rd_busy,
    input  logic [NWR-1:0]        i_wr_en,
    input  logic [NWR*AW-1:0]     i_wr_idx,
    input  logic [NWR*XLEN-1:0]   i_wr_data,
    input  logic                  i_alloc_en,
    input  logic [AW-1:0]         i_alloc_idx,
    input  logic [AW-1:0]         i_dbg_idx,
    output logic [XLEN-1:0]       o_dbg_data,
    output logic                  o_ready
);

    rf_state_e         r_state, w_state_next;
    logic [AW-1:0]     r_clr_idx, w_clr_idx_next;
    logic [NREGS-1:0]  r_busy, w_busy_next;
    logic [XLEN-1:0]   r_mem [NREGS];

    logic              w_run;
    logic [NWR-1:0]    w_wr_en_q;
    logic [NREGS-1:0]  w_we;
    logic [NREGS*XLEN-1:0] w_wdata;

    assign w_run     = (r_state == RF_RUN);
    assign o_ready   = w_run;
    assign w_wr_en_q = i_wr_en & {NWR{w_run}};

    rf_write_arbiter #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_arb (
        .i_en    (w_wr_en_q),
        .i_idx   (i_wr_idx),
        .i_data  (i_wr_data),
        .o_we    (w_we),
        .o_wdata (w_wdata)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_busy_next    = r_busy;
        case (r_state)
            RF_CLEAR: begin
                w_clr_idx_next = r_clr_idx + 1'b1;
                if (r_clr_idx == AW'(NREGS - 1)) begin
                    w_state_next = RF_RUN;
                end
            end
            RF_RUN: begin
                // Allocation is applied after the clear so it wins on a tie.
                w_busy_next = r_busy & ~w_we;
                if (i_alloc_en && !((ZERO_REG != 0) && (i_alloc_idx == '0))) begin
                    w_busy_next[i_alloc_idx] = 1'b1;
                end
            end
            default: w_state_next = RF_CLEAR;
        endcase
    end

    // Array kept free of reset so it can map onto memory resources.
    always_ff @(posedge i_clk) begin
        if (r_state == RF_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= w_wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Ports 0..NRD-1 are read ports; port NRD is the debug tap.
    logic [XLEN-1:0] w_port_data [NRD+1];

    genvar gi;
    generate
        for (gi = 0; gi < NRD + 1; gi++) begin : g_rport
            logic [AW-1:0] w_idx;
            if (gi < NRD) begin : g_rd
                assign w_idx = i_rd_idx[gi*AW +: AW];
            end else begin : g_dbg
                assign w_idx = i_dbg_idx;
            end

            always_comb begin
                w_port_data[gi] = r_mem[w_idx];
`ifdef RF_BYPASS_EN
                if (w_we[w_idx]) begin
                    w_port_data[gi] = w_wdata[w_idx*XLEN +: XLEN];
                end
`endif
                if (!w_run || ((ZERO_REG != 0) && (w_idx == '0))) begin
                    w_port_data[gi] = '0;
                end
            end

            if (gi < NRD) begin : g_out
                assign o_rd_data[gi*XLEN +: XLEN] = w_port_data[gi];
                assign o_rd_busy[gi]              = w_run & r_busy[w_idx];
            end
        end
    endgenerate

    assign o_dbg_data = w_port_data[NRD];

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench for multiport_regfile: expectations are queued when
// stimulus is driven and popped when the corresponding output is sampled.
module tb_multiport_regfile;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_idx;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_idx;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_idx;
    logic [AW-1:0]       dbg_idx;
    logic [XLEN-1:0]     dbg_data;
    logic                ready;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q [$];
    logic [XLEN-1:0] exp_v;

    always #5 clk = ~clk;

    multiport_regfile #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rd_idx    (rd_idx),
        .o_rd_data   (rd_data),
        .o_rd_busy   (rd_busy),
        .i_wr_en     (wr_en),
        .i_wr_idx    (wr_idx),
        .i_wr_data   (wr_data),
        .i_alloc_en  (alloc_en),
        .i_alloc_idx (alloc_idx),
        .i_dbg_idx   (dbg_idx),
        .o_dbg_data  (dbg_data),
        .o_ready     (ready)
    );

    task automatic idle();
        wr_en    = '0;
        wr_idx   = '0;
        wr_data  = '0;
        alloc_en = 1'b0;
        alloc_idx = '0;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_idx = {AW'(p1), AW'(p0)};
    endtask

    // Counts edges until ready; returns cycle count (bounded).
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        idle();
        set_rd(5, 0);
        dbg_idx = 5'd5;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=0", ready);
        end
        checks++;
        if (rd_data !== '0 || dbg_data !== '0 || rd_busy !== '0) begin
            failures++;
            $display("FAIL reset_outputs rd=%h dbg=%h busy=%b exp=0", rd_data, dbg_data, rd_busy);
        end
        // Writes and allocations during CLEAR must be discarded.
        wr_en = 2'b11;
        wr_idx = {AW'(5), AW'(5)};
        wr_data = {32'h55555555, 32'h66666666};
        alloc_en = 1'b1;
        alloc_idx = 5'd5;
        reset = 1'b0;
        wait_ready(cyc);
        checks++;
        if (cyc !== NREGS) begin
            failures++;
            $display("FAIL ready_latency got=%0d exp=%0d", cyc, NREGS);
        end
        $display("reset release: ready after %0d cycles", cyc);
        @(negedge clk);
        idle();
        #1;
        for (int r = 0; r < NREGS; r++) begin
            set_rd(r, NREGS - 1 - r);
            dbg_idx = AW'(r);
            #1;
            checks++;
            if (rd_data !== '0 || dbg_data !== '0 || rd_busy !== '0) begin
                failures++;
                $display("FAIL clear_x%0d rd=%h dbg=%h busy=%b exp=0", r, rd_data, dbg_data, rd_busy);
            end
        end
        $display("post-clear scan: x0..x%0d read zero/not busy checked", NREGS - 1);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_en = 2'b01;
        wr_idx = {AW'(0), AW'(10)};
        wr_data = {32'h0, 32'hDEADBEEF};
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        idle();
        set_rd(10, 10);
        dbg_idx = 5'd10;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_data[31:0] !== exp_v || rd_data[63:32] !== exp_v || dbg_data !== exp_v) begin
            failures++;
            $display("FAIL write_x10 rd0=%h rd1=%h dbg=%h exp=%h", rd_data[31:0], rd_data[63:32], dbg_data, exp_v);
        end
        $display("write x10: rd0=%h dbg=%h", rd_data[31:0], dbg_data);
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en = 2'b10;
        wr_idx = {AW'(0), AW'(3)};
        wr_data = {32'h00001234, 32'h0};
        alloc_en = 1'b1;
        alloc_idx = 5'd0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        idle();
        set_rd(0, 0);
        dbg_idx = 5'd0;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_data[31:0] !== exp_v || dbg_data !== exp_v || rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg rd=%h dbg=%h busy=%b exp=%h/0", rd_data[31:0], dbg_data, rd_busy[0], exp_v);
        end
        $display("write x0: rd0=%h busy=%b", rd_data[31:0], rd_busy[0]);
    endtask

    task automatic test_priority();
        @(negedge clk);
        wr_en = 2'b11;
        wr_idx = {AW'(7), AW'(7)};
        wr_data = {32'h22222222, 32'h11111111};
        exp_q.push_back(32'h22222222);
        @(negedge clk);
        idle();
        set_rd(7, 10);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_data[31:0] !== exp_v) begin
            failures++;
            $display("FAIL priority_x7 got=%h exp=%h", rd_data[31:0], exp_v);
        end
        checks++;
        if (rd_data[63:32] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL priority_x10_kept got=%h exp=deadbeef", rd_data[63:32]);
        end
        $display("dual write x7: got=%h", rd_data[31:0]);
    endtask

    task automatic test_busy();
        set_rd(3, 4);
        @(negedge clk);
        alloc_en = 1'b1;
        alloc_idx = 5'd3;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL busy_no_bypass got=%b exp=0", rd_busy[0]);
        end
        exp_q.push_back(32'd1);
        @(negedge clk);
        idle();
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_busy !== {1'b0, exp_v[0]}) begin
            failures++;
            $display("FAIL busy_alloc got=%b exp=0%b", rd_busy, exp_v[0]);
        end
        $display("alloc x3: busy=%b", rd_busy);
        wr_en = 2'b01;
        wr_idx = {AW'(0), AW'(3)};
        wr_data = {32'h0, 32'h33333333};
        exp_q.push_back(32'd0);
        @(negedge clk);
        idle();
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_busy[0] !== exp_v[0] || rd_data[31:0] !== 32'h33333333) begin
            failures++;
            $display("FAIL busy_clear busy=%b data=%h exp=%b/33333333", rd_busy[0], rd_data[31:0], exp_v[0]);
        end
        $display("write x3: busy=%b data=%h", rd_busy[0], rd_data[31:0]);
        wr_en = 2'b10;
        wr_idx = {AW'(3), AW'(0)};
        wr_data = {32'h44444444, 32'h0};
        alloc_en = 1'b1;
        alloc_idx = 5'd3;
        exp_q.push_back(32'd1);
        @(negedge clk);
        idle();
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_busy[0] !== exp_v[0] || rd_data[31:0] !== 32'h44444444) begin
            failures++;
            $display("FAIL busy_alloc_wins busy=%b data=%h exp=%b/44444444", rd_busy[0], rd_data[31:0], exp_v[0]);
        end
        $display("alloc+write x3: busy=%b data=%h", rd_busy[0], rd_data[31:0]);
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 2'b01;
        wr_idx = {AW'(0), AW'(4)};
        wr_data = {32'h0, 32'h01010101};
        @(negedge clk);
        wr_en = 2'b01;
        wr_idx = {AW'(0), AW'(4)};
        wr_data = {32'h0, 32'hA5A5A5A5};
        set_rd(4, 0);
        dbg_idx = 5'd4;
`ifdef RF_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(32'h01010101);
`endif
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_data[31:0] !== exp_v || dbg_data !== exp_v) begin
            failures++;
            $display("FAIL bypass_same_cycle rd=%h dbg=%h exp=%h", rd_data[31:0], dbg_data, exp_v);
        end
        $display("same-cycle read x4: rd=%h dbg=%h", rd_data[31:0], dbg_data);
        exp_q.push_back(32'hA5A5A5A5);
        @(negedge clk);
        idle();
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_data[31:0] !== exp_v) begin
            failures++;
            $display("FAIL bypass_next_cycle got=%h exp=%h", rd_data[31:0], exp_v);
        end
        $display("next-cycle read x4: rd=%h", rd_data[31:0]);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        set_rd(10, 10);
        dbg_idx = 5'd10;
        @(negedge clk);
        alloc_en = 1'b1;
        alloc_idx = 5'd10;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd_busy !== 2'b11) begin
            failures++;
            $display("FAIL mid_run_busy_set got=%b exp=11", rd_busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || rd_busy !== '0 || rd_data !== '0) begin
            failures++;
            $display("FAIL mid_run_reset ready=%b busy=%b rd=%h exp=0", ready, rd_busy, rd_data);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_ready(cyc);
        checks++;
        if (cyc !== NREGS) begin
            failures++;
            $display("FAIL mid_run_ready_latency got=%0d exp=%0d", cyc, NREGS);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rd_data[31:0] !== '0 || dbg_data !== '0 || rd_busy !== '0) begin
            failures++;
            $display("FAIL mid_run_x10_cleared rd=%h dbg=%h busy=%b exp=0", rd_data[31:0], dbg_data, rd_busy);
        end
        $display("reset mid-run: ready after %0d, x10=%h busy=%b", cyc, rd_data[31:0], rd_busy);
    endtask

    initial begin
        reset = 1'b1;
        dbg_idx = '0;
        rd_idx = '0;
        idle();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_priority();
        test_busy();
        test_bypass();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
